// File: rtl/cp0_reg_file_if.sv
// CP0 register file bus: MTC0/MFC0 access, exception/ERET commit,
// interrupt lines and the architectural register views.
interface cp0_reg_file_if;
    logic        cp0_write_en;
    logic [7:0]  cp0_write_addr;
    logic [31:0] cp0_write_data;
    logic [7:0]  cp0_read_addr;
    logic [31:0] cp0_read_data_o;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic [31:0] exc_badvaddr;
    logic        eret_valid;
    logic [5:0]  int_i;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        int_req_o;

    // Pipeline side: drives commits and read addresses.
    modport master (
        output cp0_write_en, cp0_write_addr, cp0_write_data, cp0_read_addr,
        output exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr,
        output eret_valid, int_i,
        input  cp0_read_data_o, status_o, cause_o, epc_o, int_req_o
    );

    // Register file side.
    modport slave (
        input  cp0_write_en, cp0_write_addr, cp0_write_data, cp0_read_addr,
        input  exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr,
        input  eret_valid, int_i,
        output cp0_read_data_o, status_o, cause_o, epc_o, int_req_o
    );
endinterface

// File: rtl/cp0_reg_file.sv
// CP0 register file: BadVAddr, Count/Compare timer, Status, Cause, EPC,
// Config0; MTC0 writes, exception/ERET updates and interrupt request.
module cp0_reg_file (
    input logic           clk,
    input logic           rst,
    cp0_reg_file_if.slave bus
);
    localparam logic [7:0] ADDR_BADVADDR = 8'h40;
    localparam logic [7:0] ADDR_COUNT    = 8'h48;
    localparam logic [7:0] ADDR_COMPARE  = 8'h58;
    localparam logic [7:0] ADDR_STATUS   = 8'h60;
    localparam logic [7:0] ADDR_CAUSE    = 8'h68;
    localparam logic [7:0] ADDR_EPC      = 8'h70;
    localparam logic [7:0] ADDR_CONFIG0  = 8'h80;
    localparam logic [31:0] CONFIG0_VAL  = 32'h8000_0000;

    // Status fields (BEV is a hardwired 1 in the composed view)
    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;

    // Cause fields
    logic        cause_bd;
    logic        cause_ti;
    logic [5:0]  cause_ip_hw;
    logic [1:0]  cause_ip_sw;
    logic [4:0]  cause_exc;

    logic [31:0] epc;
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] badvaddr;
    logic        tick;

    logic [31:0] status_val;
    logic [31:0] cause_val;

    logic wr_count;
    logic wr_compare;
    logic wr_status;
    logic wr_cause;
    logic wr_epc;

    // MTC0 target decode
    always_comb begin
        wr_count   = bus.cp0_write_en && (bus.cp0_write_addr == ADDR_COUNT);
        wr_compare = bus.cp0_write_en && (bus.cp0_write_addr == ADDR_COMPARE);
        wr_status  = bus.cp0_write_en && (bus.cp0_write_addr == ADDR_STATUS);
        wr_cause   = bus.cp0_write_en && (bus.cp0_write_addr == ADDR_CAUSE);
        wr_epc     = bus.cp0_write_en && (bus.cp0_write_addr == ADDR_EPC);
    end

    // Status: MTC0 loads IM/EXL/IE, then exception/ERET override EXL
    always_ff @(posedge clk) begin
        if (rst) begin
            status_im  <= '0;
            status_exl <= 1'b0;
            status_ie  <= 1'b0;
        end else begin
            if (wr_status) begin
                status_im  <= bus.cp0_write_data[15:8];
                status_exl <= bus.cp0_write_data[1];
                status_ie  <= bus.cp0_write_data[0];
            end
            if (bus.exc_valid) begin
                status_exl <= 1'b1;
            end else if (bus.eret_valid) begin
                status_exl <= 1'b0;
            end
        end
    end

    // Cause: hardware IP sampled every cycle, timer interrupt, exception info
    always_ff @(posedge clk) begin
        if (rst) begin
            cause_bd    <= 1'b0;
            cause_ti    <= 1'b0;
            cause_ip_hw <= '0;
            cause_ip_sw <= '0;
            cause_exc   <= '0;
        end else begin
            cause_ip_hw <= {bus.int_i[5] | cause_ti, bus.int_i[4:0]};
            if (wr_cause) begin
                cause_ip_sw <= bus.cp0_write_data[9:8];
            end
            if (wr_compare) begin
                cause_ti <= 1'b0;
            end else if (count == compare) begin
                cause_ti <= 1'b1;
            end
            if (bus.exc_valid) begin
                cause_exc <= bus.exc_code;
                if (!status_exl) begin
                    cause_bd <= bus.exc_bd;
                end
            end
        end
    end

    // EPC: an exception commit owns EPC that cycle, even when nested
    always_ff @(posedge clk) begin
        if (rst) begin
            epc <= '0;
        end else if (bus.exc_valid) begin
            if (!status_exl) begin
                epc <= bus.exc_bd ? (bus.exc_pc - 32'd4) : bus.exc_pc;
            end
        end else if (wr_epc) begin
            epc <= bus.cp0_write_data;
        end
    end

    // Count runs at half clock rate; MTC0 beats the increment, tick free-runs
    always_ff @(posedge clk) begin
        if (rst) begin
            tick  <= 1'b0;
            count <= '0;
        end else begin
            tick <= ~tick;
            if (wr_count) begin
                count <= bus.cp0_write_data;
            end else if (tick) begin
                count <= count + 32'd1;
            end
        end
    end

    // Compare register
    always_ff @(posedge clk) begin
        if (rst) begin
            compare <= '0;
        end else if (wr_compare) begin
            compare <= bus.cp0_write_data;
        end
    end

    // BadVAddr captures the faulting address on address-error exceptions
    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr <= '0;
        end else if (bus.exc_valid && ((bus.exc_code == 5'h04) || (bus.exc_code == 5'h05))) begin
            badvaddr <= bus.exc_badvaddr;
        end
    end

    // Compose architectural views and the interrupt request
    always_comb begin
        status_val = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
        cause_val  = {cause_bd, cause_ti, 14'b0, cause_ip_hw, cause_ip_sw,
                      1'b0, cause_exc, 2'b0};
        bus.status_o  = status_val;
        bus.cause_o   = cause_val;
        bus.epc_o     = epc;
        bus.int_req_o = ~rst & status_ie & ~status_exl
                        & (|(cause_val[15:8] & status_val[15:8]));
    end

    // MFC0 read mux, zero latency, shows pre-write state
    always_comb begin
        bus.cp0_read_data_o = '0;
        case (bus.cp0_read_addr)
            ADDR_BADVADDR: bus.cp0_read_data_o = badvaddr;
            ADDR_COUNT:    bus.cp0_read_data_o = count;
            ADDR_COMPARE:  bus.cp0_read_data_o = compare;
            ADDR_STATUS:   bus.cp0_read_data_o = status_val;
            ADDR_CAUSE:    bus.cp0_read_data_o = cause_val;
            ADDR_EPC:      bus.cp0_read_data_o = epc;
            ADDR_CONFIG0:  bus.cp0_read_data_o = CONFIG0_VAL;
            default:       bus.cp0_read_data_o = '0;
        endcase
    end
endmodule
